// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory-game core: FSM states, LFSR seed/taps, width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        LOSE,
        WIN
    } state_e;

    // Maximal-length 16-bit Fibonacci LFSR, taps 16,14,13,11 in right-shift form
    // (feedback = bit0 ^ bit2 ^ bit3 ^ bit5, shifted in at bit 15).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Width of a button index.
    function automatic int calc_bw(input int num_btns);
        return (num_btns <= 2) ? 1 : $clog2(num_btns);
    endfunction

    // Width able to hold 0..max_len inclusive.
    function automatic int calc_lw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying pseudo-random tones; never reaches zero.
// Latency: new value every clk cycle.
// Backpressure: none, always steps.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value: parity of tapped bits enters at the top, register shifts right.
    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    // Seeded on reset, then stepped on every clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/simon_core.sv
// Simon memory game: grows a random tone sequence, plays it back, then checks player presses.
// Latency: press processed on the cycle it is sampled; result visible next cycle. Button echo is same-cycle.
// Backpressure: none; presses outside WAIT_IN and start outside IDLE/LOSE/WIN are dropped.
// Optional: define SIMON_TIMEOUT_EN to add the player inactivity timeout.
module simon_core
    import simon_pkg::*;
#(
    parameter int NUM_BTNS      = 4,
    parameter int MAX_LEN       = 16,
    parameter int TONE_TICKS    = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 40,
    localparam int BW           = calc_bw(NUM_BTNS),
    localparam int LW           = calc_lw(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic          btn_valid,
    input  logic [BW-1:0] btn_num,
    output logic          simon_turn,
    output logic          play,
    output logic [BW-1:0] play_num,
    output logic          game_over,
    output logic          win,
    output logic [LW-1:0] score
);

    // Memory address width and shared tick-timer width.
    localparam int AW   = $clog2(MAX_LEN);
    localparam int T1   = (TONE_TICKS > GAP_TICKS) ? TONE_TICKS : GAP_TICKS;
    localparam int TMAX = (T1 > TIMEOUT_TICKS) ? T1 : TIMEOUT_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
`endif
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

    state_e          state_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx_q;
    logic [LW-1:0]   score_q;
    logic [TW-1:0]   timer_q;
    logic            over_q;
    logic            win_q;
    logic [BW-1:0]   mem_q [MAX_LEN];

    logic [15:0]     lfsr;
    logic            lfsr_unused;
    logic [LW-1:0]   idx_last;
    logic [BW-1:0]   cur_tone;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr)
    );

    // Only the low bits pick a tone; the rest of the LFSR state is not needed here.
    assign lfsr_unused = ^lfsr[15:BW];

    assign idx_last = len_q - 1'b1;
    assign cur_tone = mem_q[idx_q[AW-1:0]];

    // Sequence memory: one new tone appended per round, never cleared.
    always_ff @(posedge clk) begin
        if (state_q == ADD) begin
            mem_q[len_q[AW-1:0]] <= lfsr[BW-1:0];
        end
    end

    // Game FSM with sequence length, playback index, score and tick timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
            timer_q <= '0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOSE, WIN: begin
                    if (start) begin
                        len_q   <= '0;
                        score_q <= '0;
                        over_q  <= 1'b0;
                        win_q   <= 1'b0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    len_q   <= len_q + 1'b1;
                    idx_q   <= '0;
                    timer_q <= '0;
                    state_q <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (tick) begin
                        if (timer_q == TONE_LAST) begin
                            timer_q <= '0;
                            state_q <= SHOW_OFF;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                SHOW_OFF: begin
                    if (tick) begin
                        if (timer_q == GAP_LAST) begin
                            // Timer leaves at zero, so WAIT_IN starts with a cleared timeout count.
                            timer_q <= '0;
                            if (idx_q == idx_last) begin
                                idx_q   <= '0;
                                state_q <= WAIT_IN;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= SHOW_ON;
                            end
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                WAIT_IN: begin
                    if (btn_valid) begin
                        // A press wins over a coincident tick: it is judged and the idle count restarts.
                        timer_q <= '0;
                        if (btn_num != cur_tone) begin
                            over_q  <= 1'b1;
                            state_q <= LOSE;
                        end else if (idx_q != idx_last) begin
                            idx_q <= idx_q + 1'b1;
                        end else begin
                            score_q <= len_q;
                            idx_q   <= '0;
                            if (len_q == LEN_MAX) begin
                                win_q   <= 1'b1;
                                state_q <= WIN;
                            end else begin
                                state_q <= ADD;
                            end
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (tick) begin
                        if (timer_q == TO_LAST) begin
                            over_q  <= 1'b1;
                            state_q <= LOSE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tone output: stored tone during playback, live echo of presses while waiting for input.
    always_comb begin
        play     = 1'b0;
        play_num = '0;
        case (state_q)
            SHOW_ON: begin
                play     = 1'b1;
                play_num = cur_tone;
            end
            WAIT_IN: begin
                play     = btn_valid;
                play_num = btn_num;
            end
            default: begin
                play     = 1'b0;
                play_num = '0;
            end
        endcase
    end

    assign simon_turn = (state_q == ADD) || (state_q == SHOW_ON) || (state_q == SHOW_OFF);
    assign game_over  = over_q;
    assign win        = win_q;
    assign score      = score_q;

endmodule
